// File: rtl/agex_exec_unit.sv
// agex_exec_unit -- single-issue execute stage (ALU, branch resolve, optional
// shift-add multiplier) with a one-entry registered output.
//
// Build option: define AGEX_MUL_EN to include the multiplier and the BUSY
// state. Without it, op codes 20/21 behave as undefined single-cycle ops.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush              squash in-flight work (multiply or held result)
//   in_valid/in_ready  upstream handshake
//   in_op, in_pc, in_rs1, in_rs2, in_imm, in_use_imm, in_rd, in_wr_reg
//                      operation fields
//   out_valid/out_ready downstream handshake
//   out_result, out_rd, out_wr_reg, br_taken, br_target
//                      registered result fields (meaningful while out_valid)
//   dbg_state          current FSM state (0 EMPTY, 1 BUSY, 2 FULL)
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// valid never depends on ready on either side; in_ready depends on the
// output-side ready because the single output entry can be refilled in the
// same cycle it drains.
module agex_exec_unit #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_op,
  input  logic [DBITS-1:0]     in_pc,
  input  logic [DBITS-1:0]     in_rs1,
  input  logic [DBITS-1:0]     in_rs2,
  input  logic [DBITS-1:0]     in_imm,
  input  logic                 in_use_imm,
  input  logic [REGNOBITS-1:0] in_rd,
  input  logic                 in_wr_reg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DBITS-1:0]     out_result,
  output logic [REGNOBITS-1:0] out_rd,
  output logic                 out_wr_reg,
  output logic                 br_taken,
  output logic [DBITS-1:0]     br_target,
  output logic [1:0]           dbg_state
);

  localparam int SHW = $clog2(DBITS);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_LUI   = 5'd10;
  localparam logic [4:0] OP_AUIPC = 5'd11;
  localparam logic [4:0] OP_JAL   = 5'd12;
  localparam logic [4:0] OP_JALR  = 5'd13;
  localparam logic [4:0] OP_BEQ   = 5'd14;
  localparam logic [4:0] OP_BNE   = 5'd15;
  localparam logic [4:0] OP_BLT   = 5'd16;
  localparam logic [4:0] OP_BGE   = 5'd17;
  localparam logic [4:0] OP_BLTU  = 5'd18;
  localparam logic [4:0] OP_BGEU  = 5'd19;
`ifdef AGEX_MUL_EN
  localparam logic [4:0] OP_MUL   = 5'd20;
  localparam logic [4:0] OP_MULHU = 5'd21;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DBITS-1:0]       result_q, result_d;
  logic [REGNOBITS-1:0]   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   taken_q, taken_d;
  logic [DBITS-1:0]       target_q, target_d;

  // ---------------------------------------------------------------
  // Single-cycle datapath, evaluated on the incoming operation
  // ---------------------------------------------------------------
  logic [DBITS-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic [DBITS-1:0] jalr_sum;
  logic [DBITS-1:0] alu_res;
  logic [DBITS-1:0] alu_tgt;
  logic             alu_wr;
  logic             alu_taken;
  logic             alu_is_mul;
`ifdef AGEX_MUL_EN
  logic             alu_mul_hi;
`endif

  assign op_b     = in_use_imm ? in_imm : in_rs2;
  assign shamt    = op_b[SHW-1:0];
  assign jalr_sum = in_rs1 + in_imm;

  always_comb begin
    alu_res    = '0;
    alu_tgt    = '0;
    alu_wr     = in_wr_reg;
    alu_taken  = 1'b0;
    alu_is_mul = 1'b0;
`ifdef AGEX_MUL_EN
    alu_mul_hi = 1'b0;
`endif
    case (in_op)
      OP_ADD:   alu_res = in_rs1 + op_b;
      OP_SUB:   alu_res = in_rs1 - op_b;
      OP_AND:   alu_res = in_rs1 & op_b;
      OP_OR:    alu_res = in_rs1 | op_b;
      OP_XOR:   alu_res = in_rs1 ^ op_b;
      OP_SLT:   alu_res = {{(DBITS-1){1'b0}}, ($signed(in_rs1) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(DBITS-1){1'b0}}, (in_rs1 < op_b)};
      OP_SLL:   alu_res = in_rs1 << shamt;
      OP_SRL:   alu_res = in_rs1 >> shamt;
      OP_SRA:   alu_res = $signed(in_rs1) >>> shamt;
      OP_LUI:   alu_res = in_imm;
      OP_AUIPC: alu_res = in_pc + in_imm;
      OP_JAL: begin
        alu_res   = in_pc + DBITS'(4);
        alu_taken = 1'b1;
        alu_tgt   = in_pc + in_imm;
      end
      OP_JALR: begin
        alu_res   = in_pc + DBITS'(4);
        alu_taken = 1'b1;
        alu_tgt   = {jalr_sum[DBITS-1:1], 1'b0};
      end
      // Branches always compare rs1 against rs2; the immediate is only the offset.
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_wr  = 1'b0;
        alu_tgt = in_pc + in_imm;
        case (in_op)
          OP_BEQ:  alu_taken = (in_rs1 == in_rs2);
          OP_BNE:  alu_taken = (in_rs1 != in_rs2);
          OP_BLT:  alu_taken = ($signed(in_rs1) <  $signed(in_rs2));
          OP_BGE:  alu_taken = ($signed(in_rs1) >= $signed(in_rs2));
          OP_BLTU: alu_taken = (in_rs1 <  in_rs2);
          default: alu_taken = (in_rs1 >= in_rs2);
        endcase
      end
`ifdef AGEX_MUL_EN
      OP_MUL:   alu_is_mul = 1'b1;
      OP_MULHU: begin
        alu_is_mul = 1'b1;
        alu_mul_hi = 1'b1;
      end
`endif
      default:  alu_wr = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------
  // Shift-add multiplier: acc holds {partial high, remaining multiplier}.
  // Each step adds the multiplicand to the high half when the current
  // multiplier LSB is set, then shifts the whole thing right by one.
  // ---------------------------------------------------------------
`ifdef AGEX_MUL_EN
  logic [2*DBITS-1:0] acc_q, acc_d;
  logic [DBITS-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               hi_q, hi_d;
  logic [DBITS:0]     mul_sum;
  logic [2*DBITS-1:0] mul_nxt;

  assign mul_sum = {1'b0, acc_q[2*DBITS-1:DBITS]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[DBITS-1:1]};
`endif

  logic accept;

  assign in_ready  = !reset && !flush &&
                     ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_FULL);
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    taken_d  = taken_q;
    target_d = target_q;
`ifdef AGEX_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
`endif

    case (state_q)
      ST_EMPTY: state_d = ST_EMPTY;
      ST_FULL:  if (out_ready) state_d = ST_EMPTY;
`ifdef AGEX_MUL_EN
      ST_BUSY: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(DBITS-1)) begin
          state_d  = ST_FULL;
          result_d = hi_q ? mul_nxt[2*DBITS-1:DBITS] : mul_nxt[DBITS-1:0];
        end
      end
`endif
      default:  state_d = ST_EMPTY;
    endcase

    // accept only happens from EMPTY or a draining FULL, so it overrides
    // the drain transition above. A multiply parks its destination fields
    // in the output registers while out_valid is low.
    if (accept) begin
      result_d = alu_res;
      rd_d     = in_rd;
      wr_d     = alu_wr;
      taken_d  = alu_taken;
      target_d = alu_tgt;
      state_d  = ST_FULL;
`ifdef AGEX_MUL_EN
      if (alu_is_mul) begin
        state_d = ST_BUSY;
        acc_d   = {{DBITS{1'b0}}, op_b};
        mcand_d = in_rs1;
        cnt_d   = '0;
        hi_d    = alu_mul_hi;
      end
`else
      if (alu_is_mul) state_d = ST_FULL;
`endif
    end

    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      result_q <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
`ifdef AGEX_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      taken_q  <= taken_d;
      target_q <= target_d;
`ifdef AGEX_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
`endif
    end
  end

  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign out_wr_reg = wr_q;
  assign br_taken   = taken_q;
  assign br_target  = target_q;

endmodule

// File: tb/tb_agex_exec_unit.sv
// Testbench for agex_exec_unit (DBITS = 32): table of single-cycle vectors
// streamed back-to-back, plus directed sequences for stall/flush, multiply
// latency (or undefined-op handling when AGEX_MUL_EN is absent) and reset
// in the middle of work.
module tb_agex_exec_unit;

  localparam int EW = 32 + 5 + 1 + 1 + 32;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_LUI   = 5'd10;
  localparam logic [4:0] OP_AUIPC = 5'd11;
  localparam logic [4:0] OP_JAL   = 5'd12;
  localparam logic [4:0] OP_JALR  = 5'd13;
  localparam logic [4:0] OP_BEQ   = 5'd14;
  localparam logic [4:0] OP_BNE   = 5'd15;
  localparam logic [4:0] OP_BLT   = 5'd16;
  localparam logic [4:0] OP_BGE   = 5'd17;
  localparam logic [4:0] OP_BLTU  = 5'd18;
  localparam logic [4:0] OP_BGEU  = 5'd19;
  localparam logic [4:0] OP_MUL   = 5'd20;
  localparam logic [4:0] OP_MULHU = 5'd21;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] e_res;
    logic        e_wr;
    logic        e_tk;
    logic [31:0] e_tg;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wr_reg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_reg;
  logic        br_taken;
  logic [31:0] br_target;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  agex_exec_unit #(.DBITS(32), .REGNOBITS(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wr_reg(in_wr_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_reg(out_wr_reg),
    .br_taken(br_taken), .br_target(br_target), .dbg_state(dbg_state)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;
  logic [EW-1:0]   exp_q[$];
  vec_t            vq[$];
  vec_t            mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [31:0] r, input logic [4:0] d,
                                       input logic w, input logic t, input logic [31:0] g);
    return {r, d, w, t, g};
  endfunction

  task automatic check_out(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, ".valid"},  32'(out_valid),  32'd1);
      check({name, ".result"}, out_result,      e[70:39]);
      check({name, ".rd"},     32'(out_rd),     32'(e[38:34]));
      check({name, ".wr_reg"}, 32'(out_wr_reg), 32'(e[33]));
      check({name, ".taken"},  32'(br_taken),   32'(e[32]));
      check({name, ".target"}, br_target,       e[31:0]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic addv(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm, input logic ui,
                      input logic [4:0] rd, input logic [31:0] res, input logic ewr,
                      input logic etk, input logic [31:0] etg);
    vec_t v;
    v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.use_imm = ui;
    v.rd = rd; v.wr = 1'b1; v.e_res = res; v.e_wr = ewr; v.e_tk = etk; v.e_tg = etg;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_op = v.op; in_pc = v.pc; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_use_imm = v.use_imm; in_rd = v.rd; in_wr_reg = v.wr;
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back(pk(v.e_res, v.rd, v.e_wr, v.e_tk, v.e_tg));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, ".valid"},  32'(out_valid),  32'd0);
    check({name, ".result"}, out_result,      32'd0);
    check({name, ".rd"},     32'(out_rd),     32'd0);
    check({name, ".wr_reg"}, 32'(out_wr_reg), 32'd0);
    check({name, ".taken"},  32'(br_taken),   32'd0);
    check({name, ".target"}, br_target,       32'd0);
    check({name, ".state"},  32'(dbg_state),  32'd0);
  endtask

`ifdef AGEX_MUL_EN
  // Counts edges until out_valid rises; in_ready must stay low throughout.
  task automatic wait_mul(input string name);
    int   cyc = 0;
    logic rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready || out_valid) rdy_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, ".busy_cycles"}, 32'(cyc), 32'd32);
    check({name, ".ready_low"},   32'(rdy_seen), 32'd0);
  endtask
`endif

  // ---------------- test ----------------
  initial begin
    // Vector table: op, pc, rs1, rs2, imm, use_imm, rd, exp result, exp wr, exp taken, exp target
    addv(OP_ADD,   32'h0,   32'hFFFFFFFF, 32'h0,        32'h2,        1'b1, 5'd1,  32'h00000001, 1'b1, 1'b0, 32'h0);
    addv(OP_SUB,   32'h0,   32'h5,        32'h7,        32'h0,        1'b0, 5'd2,  32'hFFFFFFFE, 1'b1, 1'b0, 32'h0);
    addv(OP_AND,   32'h0,   32'hF0F0,     32'h0FF0,     32'h0,        1'b0, 5'd3,  32'h000000F0, 1'b1, 1'b0, 32'h0);
    addv(OP_OR,    32'h0,   32'hF000,     32'h000F,     32'h0,        1'b0, 5'd4,  32'h0000F00F, 1'b1, 1'b0, 32'h0);
    addv(OP_XOR,   32'h0,   32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        1'b0, 5'd5,  32'hF0F00F0F, 1'b1, 1'b0, 32'h0);
    addv(OP_SLT,   32'h0,   32'hFFFFFFFE, 32'h1,        32'h0,        1'b0, 5'd6,  32'h00000001, 1'b1, 1'b0, 32'h0);
    addv(OP_SLTU,  32'h0,   32'hFFFFFFFE, 32'h1,        32'h0,        1'b0, 5'd7,  32'h00000000, 1'b1, 1'b0, 32'h0);
    addv(OP_SLL,   32'h0,   32'h1,        32'h24,       32'h0,        1'b0, 5'd8,  32'h00000010, 1'b1, 1'b0, 32'h0);
    addv(OP_SRL,   32'h0,   32'h80000000, 32'h0,        32'h1F,       1'b1, 5'd9,  32'h00000001, 1'b1, 1'b0, 32'h0);
    addv(OP_SRA,   32'h0,   32'h80000000, 32'h4,        32'h0,        1'b0, 5'd10, 32'hF8000000, 1'b1, 1'b0, 32'h0);
    addv(OP_LUI,   32'h0,   32'hAAAA,     32'hBBBB,     32'h12345000, 1'b1, 5'd11, 32'h12345000, 1'b1, 1'b0, 32'h0);
    addv(OP_AUIPC, 32'h1000, 32'h0,       32'h0,        32'h2000,     1'b1, 5'd12, 32'h00003000, 1'b1, 1'b0, 32'h0);
    addv(OP_JAL,   32'h200, 32'h0,        32'h0,        32'h10,       1'b1, 5'd1,  32'h00000204, 1'b1, 1'b1, 32'h210);
    addv(OP_JALR,  32'h40,  32'h1001,     32'h0,        32'h4,        1'b1, 5'd13, 32'h00000044, 1'b1, 1'b1, 32'h1004);
    addv(OP_BEQ,   32'h80,  32'h9,        32'h9,        32'hFFFFFFF0, 1'b1, 5'd14, 32'h0,        1'b0, 1'b1, 32'h70);
    addv(OP_BNE,   32'h80,  32'h9,        32'h9,        32'hFFFFFFF0, 1'b0, 5'd15, 32'h0,        1'b0, 1'b0, 32'h70);
    addv(OP_BLT,   32'h100, 32'hFFFFFFFE, 32'h1,        32'h20,       1'b0, 5'd16, 32'h0,        1'b0, 1'b1, 32'h120);
    addv(OP_BLTU,  32'h100, 32'hFFFFFFFE, 32'h1,        32'h20,       1'b0, 5'd16, 32'h0,        1'b0, 1'b0, 32'h120);
    addv(OP_BGE,   32'h100, 32'h1,        32'hFFFFFFFE, 32'h20,       1'b0, 5'd17, 32'h0,        1'b0, 1'b1, 32'h120);
    addv(OP_BGEU,  32'h100, 32'h1,        32'hFFFFFFFE, 32'h20,       1'b0, 5'd17, 32'h0,        1'b0, 1'b0, 32'h120);
    addv(5'd31,    32'h0,   32'h5,        32'h5,        32'h5,        1'b1, 5'd18, 32'h0,        1'b0, 1'b0, 32'h0);
    addv(5'd22,    32'h40,  32'h5,        32'h5,        32'h5,        1'b0, 5'd18, 32'h0,        1'b0, 1'b0, 32'h0);
    addv(OP_ADD,   32'h0,   32'h7FFFFFFF, 32'h1,        32'h5,        1'b0, 5'd19, 32'h80000000, 1'b1, 1'b0, 32'h0);
`ifndef AGEX_MUL_EN
    // Without the multiplier these are undefined single-cycle ops.
    addv(OP_MUL,   32'h0,   32'h3,        32'h4,        32'h0,        1'b0, 5'd20, 32'h0,        1'b0, 1'b0, 32'h0);
    addv(OP_MULHU, 32'h0,   32'h3,        32'h4,        32'h0,        1'b0, 5'd21, 32'h0,        1'b0, 1'b0, 32'h0);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset.in_ready_after", 32'(in_ready), 32'd1);

    // Stream the table back-to-back with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      push_exp(vq[i]);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain.valid", 32'(out_valid), 32'd0);

    // Stall: held output must stay stable and block new input, then flush.
    @(negedge clk);
    in_op = OP_ADD; in_rs1 = 32'd3; in_rs2 = 32'd4; in_use_imm = 1'b0;
    in_rd = 5'd7; in_wr_reg = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check("stall.accepted", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_op = OP_SUB; in_rs1 = 32'd100; in_rd = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d.valid", k),    32'(out_valid), 32'd1);
      check($sformatf("stall%0d.result", k),   out_result, 32'd7);
      check($sformatf("stall%0d.rd", k),       32'(out_rd), 32'd7);
    end
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush.in_ready_during", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush.valid_after", 32'(out_valid), 32'd0);
    check("flush.in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("flush.nothing_accepted", 32'(out_valid), 32'd0);

`ifdef AGEX_MUL_EN
    // Multiplies: op, pc, rs1, rs2, imm, use_imm, rd, exp result...
    vq.delete();
    addv(OP_MUL,   32'h0, 32'h10000,    32'h30000, 32'h0,        1'b0, 5'd22, 32'h0,        1'b1, 1'b0, 32'h0);
    addv(OP_MULHU, 32'h0, 32'h10000,    32'h30000, 32'h0,        1'b0, 5'd23, 32'h3,        1'b1, 1'b0, 32'h0);
    addv(OP_MUL,   32'h0, 32'hFFFFFFFF, 32'h0,     32'hFFFFFFFF, 1'b1, 5'd24, 32'h1,        1'b1, 1'b0, 32'h0);
    addv(OP_MULHU, 32'h0, 32'hFFFFFFFF, 32'h0,     32'hFFFFFFFF, 1'b1, 5'd25, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0);
    addv(OP_MUL,   32'h0, 32'h7,        32'h6,     32'h0,        1'b0, 5'd26, 32'h2A,       1'b1, 1'b0, 32'h0);
    mq = vq;
    out_ready = 1'b1;
    for (int i = 0; i < mq.size(); i++) begin
      // From the second one on, the unit is FULL: transfer and accept coincide.
      @(negedge clk);
      drive(mq[i]);
      in_valid = 1'b1;
      #1;
      check($sformatf("mul%0d.in_ready", i), 32'(in_ready), 32'd1);
      push_exp(mq[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_mul($sformatf("mul%0d", i));
      check_out($sformatf("mul%0d", i));
    end
    @(negedge clk);
    @(posedge clk); #1;
    check("mul.drain", 32'(out_valid), 32'd0);

    // Reset 10 cycles into a multiply, with flush and a pending input also high.
    @(negedge clk);
    in_op = OP_MUL; in_rs1 = 32'h1234; in_rs2 = 32'h5678; in_use_imm = 1'b0;
    in_rd = 5'd21; in_wr_reg = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
`else
    // Hold a JAL result so reset has non-zero fields to clear.
    @(negedge clk);
    in_op = OP_JAL; in_pc = 32'h300; in_imm = 32'h8; in_rd = 5'd21; in_wr_reg = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold.taken", 32'(br_taken), 32'd1);
    repeat (3) @(posedge clk);
`endif
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    in_op = OP_ADD; in_rs1 = 32'd10; in_imm = 32'd20; in_use_imm = 1'b1;
    in_rd = 5'd3; in_wr_reg = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("midreset.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    #1;
    check("postreset.in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(pk(32'd30, 5'd3, 1'b1, 1'b0, 32'h0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("postreset_add");
    @(posedge clk); #1;
    check("final.drain", 32'(out_valid), 32'd0);
    check("final.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agex_exec_unit.md
AGEX_EXEC_UNIT -- requirements
Module: agex_exec_unit

Interface
REQ-001 SHALL have parameter DBITS, default 32: datapath width (>=8, power of 2).
REQ-002 SHALL have parameter REGNOBITS, default 5: destination register index width.
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  synchronous squash of all in-flight work.
REQ-006 SHALL have ports in_valid in 1 / in_ready out 1: upstream handshake; accept = in_valid & in_ready at the rising edge.
REQ-007 SHALL have ports in_op in 5, in_pc in DBITS, in_rs1 in DBITS, in_rs2 in DBITS, in_imm in DBITS (sign-extended), in_use_imm in 1, in_rd in REGNOBITS, in_wr_reg in 1.
REQ-008 SHALL have ports out_valid out 1 / out_ready in 1: downstream handshake; transfer = out_valid & out_ready.
REQ-009 SHALL have ports out_result out DBITS, out_rd out REGNOBITS, out_wr_reg out 1.
REQ-010 SHALL have ports br_taken out 1 (redirect required) and br_target out DBITS; both valid only while out_valid.

Function
REQ-011 in_op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 AUIPC, 12 JAL, 13 JALR, 14 BEQ, 15 BNE, 16 BLT, 17 BGE, 18 BLTU, 19 BGEU, 20 MUL, 21 MULHU.
REQ-012 ALU operand B SHALL be in_imm when in_use_imm = 1, else in_rs2; shift amount = B[log2(DBITS)-1:0]; results wrap modulo 2^DBITS.
REQ-013 LUI result = imm; AUIPC result = pc+imm; JAL/JALR result = pc+4, br_taken = 1; JAL target = pc+imm; JALR target = (rs1+imm) with bit 0 cleared.
REQ-014 Branches SHALL compare rs1 vs rs2 (signed for BLT/BGE, unsigned for BLTU/BGEU) regardless of in_use_imm; target = pc+imm; out_wr_reg = 0; result = 0.
REQ-015 Non-control ops SHALL drive br_taken = 0, br_target = 0.
REQ-016 Undefined op codes SHALL produce result 0, out_wr_reg = 0, br_taken = 0.
REQ-017 State machine SHALL be EMPTY, BUSY, FULL; output fields are registered in FULL.
REQ-018 EMPTY: in_ready = 1; accepting a single-cycle op -> FULL; accepting MUL/MULHU -> BUSY.
REQ-019 BUSY: in_ready = 0, out_valid = 0; shift-add multiplier, 1 bit per cycle; after exactly DBITS edges in BUSY -> FULL.
REQ-020 MUL result = low DBITS bits of the unsigned 2*DBITS-bit product; MULHU result = high DBITS bits.
REQ-021 FULL: out_valid = 1; in_ready = out_ready; transfer with accept -> FULL (single-cycle op) or BUSY (multiply); transfer without accept -> EMPTY; no transfer -> hold all outputs stable.
REQ-022 Single-cycle op latency: out_valid asserted the cycle after acceptance; back-to-back throughput 1/cycle with out_ready held at 1.
REQ-023 flush SHALL force EMPTY next edge, abort any multiply, discard held output, and override accept (in_ready = 0 while flush = 1).

Reset
REQ-024 reset SHALL force EMPTY; out_valid, out_result, out_rd, out_wr_reg, br_taken, br_target SHALL be 0; multiplier counter and accumulator cleared.
REQ-025 reset SHALL take priority over flush and over every handshake, including mid-multiply.
REQ-026 in_ready SHALL be 0 while reset = 1, and 1 the first cycle after.

Configuration
REQ-027 Macro AGEX_MUL_EN SHALL compile the multiplier and BUSY state in.
REQ-028 With AGEX_MUL_EN defined, MUL/MULHU SHALL behave per REQ-019/020.
REQ-029 Without AGEX_MUL_EN, codes 20/21 SHALL be treated as undefined (REQ-016), single-cycle, and BUSY SHALL never be entered.

Verification (DBITS = 32)
REQ-030 ADD rs1=0xFFFFFFFF, imm=2, use_imm=1, out_ready=1 -> next cycle out_valid=1, result=0x00000001.
REQ-031 BLT pc=0x100, rs1=0xFFFFFFFE, rs2=1, imm=0x20 -> br_taken=1, br_target=0x120, out_wr_reg=0; BLTU same operands -> br_taken=0.
REQ-032 JALR pc=0x40, rs1=0x1001, imm=4 -> result=0x44, br_target=0x1004, br_taken=1.
REQ-033 AGEX_MUL_EN, MUL rs1=0x10000, rs2=0x30000 -> in_ready=0 for 32 cycles, then result=0; MULHU same -> result=0x3.
REQ-034 FULL with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; flush asserted -> next cycle out_valid=0, in_ready=1.
REQ-035 reset asserted 10 cycles into a MUL -> next cycle EMPTY, all outputs 0; new ADD accepted the cycle after reset deasserts.
